// File: rtl/player_ctrl.sv
// player_ctrl: turns debounced button levels into a clamped ship X position, a rate-limited fire pulse and a game-reset pulse.
// Optional macro PLAYER_CTRL_AUTOFIRE_EN: holding fire re-fires every COOLDOWN+1 cycles while no bullet is active.
module player_ctrl #(
  parameter int X_W      = 10,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 608,
  parameter int X_START  = 304,
  parameter int STEP     = 2,
  parameter int MOVE_DIV = 250000,
  parameter int COOLDOWN = 25000000,
  parameter int CNT_W    = 25
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           d_left,
  input  logic           d_right,
  input  logic           d_fire,
  input  logic           d_reset,
  input  logic           bullet_active,
  output logic [X_W-1:0] ship_x,
  output logic           fire_pulse,
  output logic           fire_ready,
  output logic           game_rst
);

  typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef enum logic [1:0] {F_IDLE, F_FIRE, F_COOL} fstate_t;
  typedef logic [X_W:0]     xw_t;
  typedef logic [X_W-1:0]   x_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam xw_t  L_MIN       = xw_t'(X_MIN);
  localparam xw_t  L_MAX       = xw_t'(X_MAX);
  localparam xw_t  L_STEP      = xw_t'(STEP);
  localparam x_t   L_START     = x_t'(X_START);
  localparam cnt_t L_MOVE_LAST = cnt_t'(MOVE_DIV - 1);
  localparam cnt_t L_COOL_LOAD = cnt_t'(COOLDOWN - 1);

  // Saturating moves, evaluated one bit wider so the subtract cannot wrap.
  function automatic x_t sat_left(input x_t x);
    xw_t xe;
    xw_t diff;
    xe   = {1'b0, x};
    diff = xe - L_STEP;
    if (xe < L_MIN + L_STEP) sat_left = L_MIN[X_W-1:0];
    else                     sat_left = diff[X_W-1:0];
  endfunction

  function automatic x_t sat_right(input x_t x);
    xw_t xe;
    xw_t sum;
    xe  = {1'b0, x};
    sum = xe + L_STEP;
    if (xe > L_MAX - L_STEP) sat_right = L_MAX[X_W-1:0];
    else                     sat_right = sum[X_W-1:0];
  endfunction

  logic    r_fire_p0, r_reset_p0, r_edge_arm, r_game_rst;
  dir_t    r_dir;
  cnt_t    r_move_cnt, r_cool_cnt;
  x_t      r_x;
  fstate_t r_fstate;

  dir_t    w_dir;
  logic    w_fire_rise, w_reset_rise, w_fire_trig, w_step;
  cnt_t    w_move_cnt_nxt, w_cool_nxt;
  x_t      w_x_nxt;
  fstate_t w_fstate_nxt;

  // Edges are ignored until the previous-sample registers hold a real sample,
  // so a button held across reset release is not seen as a fresh press.
  assign w_fire_rise  = r_edge_arm & d_fire  & ~r_fire_p0;
  assign w_reset_rise = r_edge_arm & d_reset & ~r_reset_p0;

`ifdef PLAYER_CTRL_AUTOFIRE_EN
  assign w_fire_trig = d_fire;
`else
  assign w_fire_trig = w_fire_rise;
`endif

  always_comb begin
    w_dir = DIR_NONE;
    if (d_left && !d_right)      w_dir = DIR_LEFT;
    else if (d_right && !d_left) w_dir = DIR_RIGHT;
  end

  always_comb begin
    w_step         = 1'b0;
    w_move_cnt_nxt = '0;
    w_x_nxt        = r_x;
    w_fstate_nxt   = r_fstate;
    w_cool_nxt     = r_cool_cnt;

    if (w_dir != DIR_NONE) begin
      if (w_dir != r_dir)                   w_step = 1'b1;
      else if (r_move_cnt == L_MOVE_LAST)   w_step = 1'b1;
      else                                  w_move_cnt_nxt = r_move_cnt + 1'b1;
    end
    if (w_step) w_x_nxt = (w_dir == DIR_LEFT) ? sat_left(r_x) : sat_right(r_x);

    unique case (r_fstate)
      F_IDLE: if (w_fire_trig && !bullet_active) w_fstate_nxt = F_FIRE;
      F_FIRE: begin
        w_cool_nxt   = L_COOL_LOAD;
        w_fstate_nxt = F_COOL;
      end
      F_COOL: begin
        if (r_cool_cnt == '0) begin
`ifdef PLAYER_CTRL_AUTOFIRE_EN
          w_fstate_nxt = (d_fire && !bullet_active) ? F_FIRE : F_IDLE;
`else
          w_fstate_nxt = F_IDLE;
`endif
        end else begin
          w_cool_nxt = r_cool_cnt - 1'b1;
        end
      end
      default: w_fstate_nxt = F_IDLE;
    endcase

    // Game reset wins over any step or shot decided this cycle.
    if (w_reset_rise) begin
      w_x_nxt        = L_START;
      w_move_cnt_nxt = '0;
      w_fstate_nxt   = F_IDLE;
      w_cool_nxt     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fire_p0  <= 1'b0;
      r_reset_p0 <= 1'b0;
      r_edge_arm <= 1'b0;
      r_dir      <= DIR_NONE;
      r_move_cnt <= '0;
      r_cool_cnt <= '0;
      r_x        <= L_START;
      r_fstate   <= F_IDLE;
      r_game_rst <= 1'b0;
    end else begin
      r_fire_p0  <= d_fire;
      r_reset_p0 <= d_reset;
      r_edge_arm <= 1'b1;
      r_dir      <= w_dir;
      r_move_cnt <= w_move_cnt_nxt;
      r_cool_cnt <= w_cool_nxt;
      r_x        <= w_x_nxt;
      r_fstate   <= w_fstate_nxt;
      r_game_rst <= w_reset_rise;
    end
  end

  assign ship_x     = r_x;
  assign fire_pulse = (r_fstate == F_FIRE);
  assign fire_ready = (r_fstate == F_IDLE) && !bullet_active;
  assign game_rst   = r_game_rst;

endmodule

// File: tb/tb_player_ctrl.sv
// Scoreboard bench for player_ctrl: stimulus queues expected output events, a negedge monitor pops and checks them.
module tb_player_ctrl;
  localparam int X_W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, d_left, d_right, d_fire, d_reset, bullet_active;
  logic [X_W-1:0] ship_x;
  logic fire_pulse, fire_ready, game_rst;

  logic b_left, b_right;
  logic [X_W-1:0] b_ship_x;
  logic b_fire_pulse, b_fire_ready, b_game_rst;

  player_ctrl #(.X_W(X_W), .X_MIN(0), .X_MAX(608), .X_START(304), .STEP(2),
                .MOVE_DIV(4), .COOLDOWN(5), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .d_left(d_left), .d_right(d_right), .d_fire(d_fire),
    .d_reset(d_reset), .bullet_active(bullet_active), .ship_x(ship_x),
    .fire_pulse(fire_pulse), .fire_ready(fire_ready), .game_rst(game_rst));

  player_ctrl #(.X_W(X_W), .X_MIN(0), .X_MAX(608), .X_START(1), .STEP(2),
                .MOVE_DIV(4), .COOLDOWN(5), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .d_left(b_left), .d_right(b_right), .d_fire(1'b0),
    .d_reset(1'b0), .bullet_active(1'b0), .ship_x(b_ship_x),
    .fire_pulse(b_fire_pulse), .fire_ready(b_fire_ready), .game_rst(b_game_rst));

  typedef struct { int cyc; int val; } ev_t;
  ev_t q_ship[$];
  ev_t q_fire[$];
  ev_t q_grst[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ship(input int c, input int v);
    q_ship.push_back('{cyc: c, val: v});
  endtask
  task automatic push_fire(input int c);
    q_fire.push_back('{cyc: c, val: 1});
  endtask
  task automatic push_grst(input int c);
    q_grst.push_back('{cyc: c, val: 1});
  endtask

  logic [X_W-1:0] prev_x;

  always @(negedge clk) begin : mon
    ev_t e;
    if (rst) begin
      prev_x = ship_x;
    end else begin
      if (ship_x != prev_x) begin
        checks++;
        if (q_ship.size() == 0) begin
          errors++;
          $display("FAIL ship_x unexpected change at cycle %0d: got %0d, expected %0d", cyc, ship_x, prev_x);
        end else begin
          e = q_ship.pop_front();
          if (e.val != int'(ship_x) || e.cyc != cyc) begin
            errors++;
            $display("FAIL ship_x event: got %0d at cycle %0d, expected %0d at cycle %0d", ship_x, cyc, e.val, e.cyc);
          end
        end
        prev_x = ship_x;
      end
      if (fire_pulse) begin
        checks++;
        if (q_fire.size() == 0) begin
          errors++;
          $display("FAIL fire_pulse unexpected at cycle %0d: got 1, expected 0", cyc);
        end else begin
          e = q_fire.pop_front();
          if (e.cyc != cyc) begin
            errors++;
            $display("FAIL fire_pulse timing: got cycle %0d, expected cycle %0d", cyc, e.cyc);
          end
        end
      end
      if (game_rst) begin
        checks++;
        if (q_grst.size() == 0) begin
          errors++;
          $display("FAIL game_rst unexpected at cycle %0d: got 1, expected 0", cyc);
        end else begin
          e = q_grst.pop_front();
          if (e.cyc != cyc) begin
            errors++;
            $display("FAIL game_rst timing: got cycle %0d, expected cycle %0d", cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int c;
    int k;
    rst = 1'b1; d_left = 1'b0; d_right = 1'b0; d_fire = 1'b0; d_reset = 1'b0;
    bullet_active = 1'b0; b_left = 1'b0; b_right = 1'b0;
    tick(2);
    check("reset ship_x", int'(ship_x), 304);
    check("reset fire_pulse", int'(fire_pulse), 0);
    check("reset game_rst", int'(game_rst), 0);
    check("reset fire_ready", int'(fire_ready), 1);
    check("reset b_ship_x", int'(b_ship_x), 1);
    rst = 1'b0;
    tick(3);

    // Hold right: immediate step, then one step every 4 cycles.
    c = cyc;
    push_ship(c + 1, 306); push_ship(c + 5, 308); push_ship(c + 9, 310);
    d_right = 1'b1;
    tick(10);
    d_right = 1'b0;
    tick(4);

    // Both held is no direction.
    d_left = 1'b1; d_right = 1'b1;
    tick(6);
    d_left = 1'b0; d_right = 1'b0;
    tick(2);

    // Left entry then a direct switch to right steps again at once.
    c = cyc;
    d_left = 1'b1; push_ship(c + 1, 308);
    tick(2);
    d_left = 1'b0; d_right = 1'b1; push_ship(c + 3, 310);
    tick(2);
    d_right = 1'b0;
    tick(4);

    // Fire, press during cooldown dropped, later press accepted.
    c = cyc;
    d_fire = 1'b1; push_fire(c + 1);
    tick(1);
    d_fire = 1'b0;
    tick(2);
    check("fire_ready during cooldown", int'(fire_ready), 0);
    d_fire = 1'b1;
    tick(1);
    d_fire = 1'b0;
    tick(4);
    d_fire = 1'b1; push_fire(c + 9);
    tick(1);
    d_fire = 1'b0;
    tick(8);
    check("fire_ready idle", int'(fire_ready), 1);

    // Bullet on screen blocks and drops the press.
    bullet_active = 1'b1; d_fire = 1'b1;
    tick(1);
    check("fire_ready with bullet", int'(fire_ready), 0);
    d_fire = 1'b0;
    tick(2);
    bullet_active = 1'b0;
    tick(1);
    check("fire_ready bullet gone", int'(fire_ready), 1);
    c = cyc;
    d_fire = 1'b1; push_fire(c + 1);
    tick(1);
    d_fire = 1'b0;
    tick(8);

    // Game reset with a simultaneous fire edge: reset wins, no shot, held reset not repeated.
    c = cyc;
    d_reset = 1'b1; d_fire = 1'b1;
    push_grst(c + 1); push_ship(c + 1, 304);
    tick(1);
    d_fire = 1'b0;
    tick(5);
    d_reset = 1'b0;
    check("fire_ready after game reset", int'(fire_ready), 1);
    tick(2);

    // rst mid-cooldown with fire held through release.
    c = cyc;
    d_fire = 1'b1; push_fire(c + 1);
    tick(2);
    rst = 1'b1;
    tick(2);
    check("ship_x in rst", int'(ship_x), 304);
    check("fire_ready in rst", int'(fire_ready), 1);
    rst = 1'b0;
    k = cyc;
`ifdef PLAYER_CTRL_AUTOFIRE_EN
    push_fire(k + 1);
`endif
    tick(1);
    d_fire = 1'b0;
    tick(1);
    d_fire = 1'b1;
`ifndef PLAYER_CTRL_AUTOFIRE_EN
    push_fire(k + 3);
`endif
    tick(1);
    d_fire = 1'b0;
    tick(8);

    // Fire held: one shot, or repeated shots every COOLDOWN+1 with autofire.
    c = cyc;
    d_fire = 1'b1; push_fire(c + 1);
`ifdef PLAYER_CTRL_AUTOFIRE_EN
    push_fire(c + 7); push_fire(c + 13);
`endif
    tick(15);
    d_fire = 1'b0;
    tick(8);

    // Clamp checks on the second instance: 607 -> 608 on the right, 1 -> 0 on the left.
    b_right = 1'b1;
    tick(1300);
    check("b right clamp", int'(b_ship_x), 608);
    tick(8);
    check("b right hold at max", int'(b_ship_x), 608);
    b_right = 1'b0;
    rst = 1'b1;
    tick(1);
    check("b rst ship_x", int'(b_ship_x), 1);
    rst = 1'b0;
    tick(1);
    b_left = 1'b1;
    tick(2);
    check("b left clamp", int'(b_ship_x), 0);
    tick(8);
    check("b left hold at min", int'(b_ship_x), 0);
    b_left = 1'b0;
    tick(4);

    while (q_ship.size() != 0) begin
      checks++; errors++;
      $display("FAIL ship_x missing event: got none, expected %0d at cycle %0d", q_ship[0].val, q_ship[0].cyc);
      void'(q_ship.pop_front());
    end
    while (q_fire.size() != 0) begin
      checks++; errors++;
      $display("FAIL fire_pulse missing: got none, expected pulse at cycle %0d", q_fire[0].cyc);
      void'(q_fire.pop_front());
    end
    while (q_grst.size() != 0) begin
      checks++; errors++;
      $display("FAIL game_rst missing: got none, expected pulse at cycle %0d", q_grst[0].cyc);
      void'(q_grst.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
